router_input_fifo: RTL and testbench

//  Flit buffer between packet_generator and the router ingress port.

---
 rtl/router_input_fifo.sv | 96 +++++++++
 tb/tb_router_input_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/router_input_fifo.sv
// router_input_fifo: circular flit buffer between the packet generator and the
// router ingress port. It has valid/ready on both sides and first-word
// fall-through on the output. With STORE_FWD=1 a packet is offered only once
// its eop flit is buffered. A full buffer overrides this so that packets
// longer than DEPTH still drain and cannot deadlock the buffer.
module router_input_fifo #(
  parameter int DEPTH     = 8,
  parameter bit STORE_FWD = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_dest_addr,
  input  logic [1:0]               in_packet_type,
  input  logic [7:0]               in_payload,
  input  logic                     in_eop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_dest_addr,
  output logic [1:0]               out_packet_type,
  output logic [7:0]               out_payload,
  output logic                     out_eop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = 13;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] head;
  logic          wr_en;
  logic          rd_en;
  logic          pkt_inc;
  logic          pkt_dec;

  // Handshake qualification. in_ready is gated by reset so it is low throughout reset.
  always_comb begin
    in_ready  = reset && (count < FULL_C);
    out_valid = 1'b0;
    if (reset && (count != '0)) begin
      if (STORE_FWD) out_valid = (pkt_count != '0) || (count == FULL_C);
      else           out_valid = 1'b1;
    end
    wr_en = in_valid && in_ready;
    rd_en = out_valid && out_ready;
  end

  // Fall-through head flit. The data outputs read as zero when the buffer is empty.
  always_comb begin
    head = mem[rd_ptr];
    if (count == '0) head = '0;
    {out_dest_addr, out_packet_type, out_payload, out_eop} = head;
  end

  // Flit storage. It needs no reset because the outputs are masked by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {in_dest_addr, in_packet_type, in_payload, in_eop};
  end

  // Packet accounting. An eop read with no counted packet (forced cut-through)
  // does not underflow the count.
  always_comb begin
    pkt_inc = wr_en && in_eop;
    pkt_dec = rd_en && out_eop && (pkt_count != '0);
  end

  // Pointers and occupancy counters. Full and empty are taken from count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_count <= pkt_count + CW'(1);
        2'b01:   pkt_count <= pkt_count - CW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_router_input_fifo.sv
// Testbench for router_input_fifo (DEPTH=8, STORE_FWD=1). Each accepted flit is
// pushed into a scoreboard queue. A monitor pops the queue and compares on every
// output transfer.
module tb_router_input_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_dest_addr = '0;
  logic [1:0] in_packet_type = '0;
  logic [7:0] in_payload = '0;
  logic       in_eop = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_dest_addr;
  logic [1:0] out_packet_type;
  logic [7:0] out_payload;
  logic       out_eop;
  logic [3:0] count;
  logic [3:0] pkt_count;

  int checks = 0;
  int failures = 0;
  logic [12:0] exp_q [$];

  router_input_fifo #(.DEPTH(8), .STORE_FWD(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dest_addr(in_dest_addr), .in_packet_type(in_packet_type),
    .in_payload(in_payload), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dest_addr(out_dest_addr), .out_packet_type(out_packet_type),
    .out_payload(out_payload), .out_eop(out_eop),
    .count(count), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer takes place at the next posedge when valid and ready are high at the negedge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got %0h expected none",
                 {out_dest_addr, out_packet_type, out_payload, out_eop});
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if ({out_dest_addr, out_packet_type, out_payload, out_eop} != e) begin
          failures++;
          $display("FAIL sb_flit: got %0h expected %0h",
                   {out_dest_addr, out_packet_type, out_payload, out_eop}, e);
        end
      end
    end
  end

  // Drive one flit and hold it until it is accepted. The flit is pushed to the
  // scoreboard when it is accepted.
  task automatic send(input logic [1:0] d, input logic [1:0] t,
                      input logic [7:0] p, input logic e);
    int n;
    bit done;
    in_valid = 1'b1; in_dest_addr = d; in_packet_type = t;
    in_payload = p; in_eop = e;
    done = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      n++;
    end
    if (done) exp_q.push_back({d, t, p, e});
    else begin
      checks++; failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for payload %0h", p);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (count != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, int'(count), 0);
  endtask

  initial begin
    // 1: reset and idle
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    #20 reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_out_valid", int'(out_valid), 0);
    chk("idle_count", int'(count), 0);
    chk("idle_pkt_count", int'(pkt_count), 0);
    chk("idle_payload", int'(out_payload), 0);

    // 2: store-and-forward holds the packet until its eop flit is buffered
    out_ready = 1'b1;
    send(2'd1, 2'd0, 8'h11, 1'b0);
    chk("sf_valid_after1", int'(out_valid), 0);
    send(2'd1, 2'd0, 8'h22, 1'b0);
    chk("sf_valid_after2", int'(out_valid), 0);
    chk("sf_count2", int'(count), 2);
    send(2'd1, 2'd0, 8'h33, 1'b1);
    chk("sf_valid_after3", int'(out_valid), 1);
    chk("sf_head", int'(out_payload), 8'h11);
    chk("sf_pkt", int'(pkt_count), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("sf_stream_count", int'(count), 0);
    chk("sf_stream_pkt", int'(pkt_count), 0);

    // 3: fill with 8 single-flit packets, hold a 9th flit, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(2'(i), 2'(i + 1), 8'(8'h40 + i), 1'b1);
    chk("full_count", int'(count), 8);
    chk("full_pkt", int'(pkt_count), 8);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_head", int'(out_payload), 8'h40);
    fork
      send(2'd3, 2'd3, 8'h99, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("full_hold_count", int'(count), 8);
        chk("full_head_stable", int'(out_payload), 8'h40);
        out_ready = 1'b1;
      end
    join
    drain("full_drain");
    chk("full_drain_pkt", int'(pkt_count), 0);

    // 4: a 10-flit packet overflows the buffer and forces cut-through
    for (int i = 0; i < 8; i++) send(2'd2, 2'd1, 8'(8'h80 + i), 1'b0);
    chk("long_count8", int'(count), 8);
    chk("long_forced_valid", int'(out_valid), 1);
    chk("long_pkt0", int'(pkt_count), 0);
    send(2'd2, 2'd1, 8'h88, 1'b0);
    send(2'd2, 2'd1, 8'h89, 1'b1);
    drain("long_drain");
    chk("long_pkt_end", int'(pkt_count), 0);

    // 5: steady state at count=4 while the pointers wrap
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'd0, 2'd2, 8'(8'hA0 + i), 1'b1);
    chk("steady_pre", int'(count), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(2'd0, 2'd2, 8'(8'hB0 + i), 1'b1);
      chk("steady_count", int'(count), 4);
    end
    drain("steady_drain");

    // 6: asynchronous reset in the middle of a packet
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'd1, 2'd3, 8'(8'hC0 + i), 1'b0);
    chk("mid_count5", int'(count), 5);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_pkt", int'(pkt_count), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    exp_q.delete();
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'd3, 2'd0, 8'hD1, 1'b0);
    send(2'd3, 2'd0, 8'hD2, 1'b1);
    drain("post_rst_drain");
    chk("post_rst_pkt", int'(pkt_count), 0);

    repeat (2) @(posedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
